cnn_accel: RTL and testbench
============================

CNN_ACCEL -- requirements
Module: cnn_accel

Interface
REQ-001 Parameter IMG_N, default 5: image is IMG_N x IMG_N pixels.
REQ-002 Parameter K_N, default 3: kernel is K_N x K_N taps.
REQ-003 Parameter OUT_N, derived IMG_N-K_N+1 (default 3): output is OUT_N x OUT_N.
REQ-004 Port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port cnn_en, input, 1 bit: block enable; when low, writes and start are ignored and rdata is 0.
REQ-007 Port w_en, input, 1 bit: register write strobe, sampled at the rising edge.
REQ-008 Port w_addr, input, 32 bits: write address; only bits [11:0] are decoded.
REQ-009 Port wdata, input, 32 bits: write data.
REQ-010 Port r_en, input, 1 bit: read enable.
REQ-011 Port r_addr, input, 32 bits: read address; only bits [11:0] are decoded.
REQ-012 Port rdata, output, 32 bits: read data, combinational from r_en and r_addr.
REQ-013 Port done, output, 1 bit: computation-complete flag, registered.

Function
REQ-014 Write to 0x004 stores pixel wdata[7:0] (unsigned) at image index wdata[31:16], row-major (index = row*IMG_N+col); index >= IMG_N*IMG_N is ignored.
REQ-015 Write to 0x008 stores tap wdata[7:0] (unsigned) at kernel index wdata[31:16], row-major; index >= K_N*K_N is ignored.
REQ-016 Write to 0x00C with wdata[0]=1 while IDLE or DONE starts computation; the same cycle clears done.
REQ-017 Image and kernel writes and start writes are ignored while BUSY; writes to other addresses are ignored.
REQ-018 Operation is valid correlation with stride 1 and no kernel flip: out[r][c] = sum over i,j < K_N of img[r+i][c+j] * k[i][j].
REQ-019 Arithmetic: 8x8 unsigned products, 20-bit unsigned accumulator; the stored result is 20 bits, zero-extended on read.
REQ-020 FSM states: IDLE -> BUSY on start; BUSY performs one MAC per cycle, taps in row-major order, outputs in row-major order (OUT_N*OUT_N*K_N*K_N = 81 cycles).
REQ-021 Each result is written to the result array on the cycle of its last tap, and the accumulator clears for the next output.
REQ-022 BUSY -> DONE after the final MAC; done goes high on the next rising edge, 82 cycles after the start edge.
REQ-023 done stays high in DONE until the next accepted start (DONE -> BUSY).
REQ-024 Read 0x080 + 4*n (n < OUT_N*OUT_N) with r_en=1 returns result n; read 0x010 returns {31'b0, done}; reads of any other address, or with r_en=0, return 0.
REQ-025 Results persist until overwritten by a later computation.
REQ-026 Deasserting cnn_en while BUSY does not abort the computation in progress.

Reset
REQ-027 While rst is high: state is IDLE, done is 0, accumulator and counters are 0, and the image, kernel and result arrays are 0.
REQ-028 Reset asserted mid-computation aborts it immediately; done remains 0 after release.

Structure
REQ-029 A shared package cnn_accel_pkg holds the address constants (0x004, 0x008, 0x00C, 0x010, 0x080), the default dimensions and the FSM state enum.
REQ-030 One sub-module, cnn_mac (8x8 unsigned multiply plus 20-bit accumulate with clear), is instantiated once.

Verification
REQ-031 Load image 1..25 and kernel 1..9, then start -> after done, results 0..8 = 411, 456, 501, 636, 681, 726, 861, 906, 951.
REQ-032 Start, then count cycles -> done rises exactly 82 cycles after the start edge; reading 0x010 returns 1 only once done is high.
REQ-033 Load all pixels and taps as 255 -> every result = 585225 (0x8EE09), with no overflow.
REQ-034 Write a kernel tap and issue a second start while BUSY -> both ignored; results match REQ-031.
REQ-035 With cnn_en=0, write an image index -> pixel is unchanged; with r_en=0, rdata reads 0.
REQ-036 Assert rst mid-computation -> done is 0, all results read 0, and a fresh load plus start reproduces REQ-031.

Source files
------------

// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN convolution accelerator: register map,
// default dimensions, accumulator width, FSM state type and an index-width helper.
package cnn_accel_pkg;

  localparam int unsigned ImgNDef = 5;
  localparam int unsigned KNDef   = 3;
  localparam int unsigned AccW    = 20;

  localparam logic [11:0] AddrPix    = 12'h004;
  localparam logic [11:0] AddrKern   = 12'h008;
  localparam logic [11:0] AddrStart  = 12'h00C;
  localparam logic [11:0] AddrStatus = 12'h010;
  localparam logic [11:0] AddrRes    = 12'h080;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Bits needed to index an array of n entries (at least one).
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_mac.sv
// Multiply-accumulate unit: 8x8 unsigned product added into a 20-bit accumulator.
//   clk_i, rst_i : clock, async active-high reset
//   en_i         : perform one MAC this cycle
//   clr_i        : with en_i, clear the accumulator after this MAC (last tap)
//   a_i, b_i     : pixel and tap operands
//   sum_o        : accumulator plus current product (the value of this MAC)
module cnn_mac
  import cnn_accel_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [7:0]      a_i,
  input  logic [7:0]      b_i,
  output logic [AccW-1:0] sum_o
);

  logic [AccW-1:0] acc_q, acc_d;
  logic [15:0]     prod;

  assign prod  = a_i * b_i;
  assign sum_o = acc_q + AccW'(prod);

  always_comb begin
    acc_d = acc_q;
    if (en_i) acc_d = clr_i ? '0 : sum_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/cnn_accel.sv
// Valid-mode 2D correlation accelerator with a memory-mapped register interface.
// Image and kernel are loaded through indexed writes, a start write runs one MAC
// per cycle over all outputs, results are read back from a result window.
//   clk, rst            : clock, async active-high reset
//   cnn_en              : block enable (gates writes, start and reads)
//   w_en, w_addr, wdata : register write port
//   r_en, r_addr, rdata : combinational register read port
//   done                : registered completion flag
module cnn_accel
  import cnn_accel_pkg::*;
#(
  parameter int unsigned IMG_N = ImgNDef,
  parameter int unsigned K_N   = KNDef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnn_en,
  input  logic        w_en,
  input  logic [31:0] w_addr,
  input  logic [31:0] wdata,
  input  logic        r_en,
  input  logic [31:0] r_addr,
  output logic [31:0] rdata,
  output logic        done
);

  localparam int unsigned OUT_N  = IMG_N - K_N + 1;
  localparam int unsigned ImgNN  = IMG_N * IMG_N;
  localparam int unsigned KNN    = K_N * K_N;
  localparam int unsigned OutNN  = OUT_N * OUT_N;
  localparam int unsigned ImgIW  = idx_w(ImgNN);
  localparam int unsigned KIW    = idx_w(KNN);
  localparam int unsigned OutIW  = idx_w(OutNN);
  localparam int unsigned CW     = idx_w(IMG_N);
  localparam logic [CW-1:0] KLast   = CW'(K_N - 1);
  localparam logic [CW-1:0] OutLast = CW'(OUT_N - 1);

  logic [7:0]      img_q  [ImgNN];
  logic [7:0]      kern_q [KNN];
  logic [AccW-1:0] res_q  [OutNN];

  state_e        state_q;
  logic          done_q;
  logic [CW-1:0] out_r_q, out_c_q, k_i_q, k_j_q;

  logic [11:0]      waddr, raddr, res_off;
  logic             wr_ok, start, busy, last_tap;
  logic [ImgIW-1:0] pix_idx;
  logic [KIW-1:0]   kern_idx;
  logic [OutIW-1:0] out_idx;
  logic [AccW-1:0]  mac_sum;
  logic             unused;

  assign waddr  = w_addr[11:0];
  assign raddr  = r_addr[11:0];
  assign unused = ^{w_addr[31:12], r_addr[31:12], wdata[15:8]};

  assign busy     = (state_q == StBusy);
  assign wr_ok    = cnn_en && w_en && !busy;
  assign start    = wr_ok && (waddr == AddrStart) && wdata[0];
  assign last_tap = (k_i_q == KLast) && (k_j_q == KLast);

  assign pix_idx  = (ImgIW'(out_r_q) + ImgIW'(k_i_q)) * ImgIW'(IMG_N)
                  + ImgIW'(out_c_q) + ImgIW'(k_j_q);
  assign kern_idx = KIW'(k_i_q) * KIW'(K_N) + KIW'(k_j_q);
  assign out_idx  = OutIW'(out_r_q) * OutIW'(OUT_N) + OutIW'(out_c_q);

  cnn_mac u_mac (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (busy),
    .clr_i (last_tap),
    .a_i   (img_q[pix_idx]),
    .b_i   (kern_q[kern_idx]),
    .sum_o (mac_sum)
  );

  // Control FSM: tap counters nest inside output counters, all row-major.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      out_r_q <= '0;
      out_c_q <= '0;
      k_i_q   <= '0;
      k_j_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StBusy;
        end
        StBusy: begin
          if (k_j_q != KLast) begin
            k_j_q <= k_j_q + 1'b1;
          end else begin
            k_j_q <= '0;
            if (k_i_q != KLast) begin
              k_i_q <= k_i_q + 1'b1;
            end else begin
              k_i_q <= '0;
              if (out_c_q != OutLast) begin
                out_c_q <= out_c_q + 1'b1;
              end else begin
                out_c_q <= '0;
                if (out_r_q != OutLast) begin
                  out_r_q <= out_r_q + 1'b1;
                end else begin
                  out_r_q <= '0;
                  state_q <= StDone;
                end
              end
            end
          end
        end
        StDone: begin
          // done rises one edge after the final MAC and holds until a new start.
          if (start) begin
            state_q <= StBusy;
            done_q  <= 1'b0;
          end else begin
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage: image/kernel loads from the bus, results from the MAC on each last tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ImgNN); i++) img_q[i]  <= '0;
      for (int i = 0; i < int'(KNN); i++)   kern_q[i] <= '0;
      for (int i = 0; i < int'(OutNN); i++) res_q[i]  <= '0;
    end else begin
      if (wr_ok && (waddr == AddrPix) && (wdata[31:16] < 16'(ImgNN))) begin
        img_q[wdata[16 +: ImgIW]] <= wdata[7:0];
      end
      if (wr_ok && (waddr == AddrKern) && (wdata[31:16] < 16'(KNN))) begin
        kern_q[wdata[16 +: KIW]] <= wdata[7:0];
      end
      if (busy && last_tap) res_q[out_idx] <= mac_sum;
    end
  end

  assign res_off = raddr - AddrRes;

  always_comb begin
    rdata = '0;
    if (cnn_en && r_en) begin
      if (raddr == AddrStatus) begin
        rdata = {31'b0, done_q};
      end else if ((raddr >= AddrRes) && (res_off[1:0] == 2'b00) &&
                   (res_off[11:2] < 10'(OutNN))) begin
        rdata = 32'(res_q[res_off[2 +: OutIW]]);
      end
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_cnn_accel.sv
// Self-checking bench for cnn_accel: directed register-map scenarios plus
// randomized image/kernel loads checked against a plain-arithmetic correlation model.
module tb_cnn_accel;
  import cnn_accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst, cnn_en, w_en, r_en, done;
  logic [31:0] w_addr, wdata, r_addr, rdata;

  cnn_accel u_dut (
    .clk    (clk),
    .rst    (rst),
    .cnn_en (cnn_en),
    .w_en   (w_en),
    .w_addr (w_addr),
    .wdata  (wdata),
    .r_en   (r_en),
    .r_addr (r_addr),
    .rdata  (rdata),
    .done   (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_vec = 0;
  int n_err = 0;
  int img_m [25];
  int ker_m [9];
  int exp_m [9];
  int unsigned start_cyc;
  logic [31:0] rd_val;

  localparam int DirExp [9] = '{411, 456, 501, 636, 681, 726, 861, 906, 951};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    w_en = 1'b1; w_addr = {20'b0, a}; wdata = d;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    r_en = 1'b1; r_addr = {20'b0, a};
    #1 d = rdata;
    r_en = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 25; i++) wr(AddrPix, {16'(i), 8'h00, 8'(img_m[i])});
    for (int i = 0; i < 9; i++)  wr(AddrKern, {16'(i), 8'h00, 8'(ker_m[i])});
  endtask

  // Valid correlation straight from the definition.
  task automatic compute_model();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) s += img_m[(r + i) * 5 + c + j] * ker_m[i * 3 + j];
        exp_m[r * 3 + c] = s & 20'hFFFFF;
      end
  endtask

  task automatic set_directed();
    for (int i = 0; i < 25; i++) img_m[i] = i + 1;
    for (int i = 0; i < 9; i++)  ker_m[i] = i + 1;
    for (int i = 0; i < 9; i++)  exp_m[i] = DirExp[i];
  endtask

  task automatic start();
    @(negedge clk);
    w_en = 1'b1; w_addr = {20'b0, AddrStart}; wdata = 32'd1;
    @(posedge clk);
    #1 start_cyc = cyc_cnt;
    w_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_latency"}, 32'(cyc_cnt - start_cyc), 32'd82);
  endtask

  task automatic check_results(input string tag);
    for (int n = 0; n < 9; n++) begin
      rd(AddrRes + 12'(4 * n), rd_val);
      check($sformatf("%s_res%0d", tag, n), rd_val, 32'(exp_m[n]));
    end
  endtask

  initial begin
    rst = 1'b1; cnn_en = 1'b1; w_en = 1'b0; r_en = 1'b0;
    w_addr = '0; wdata = '0; r_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("rst_done", {31'b0, done}, 32'd0);
    r_en = 1'b1; r_addr = {20'b0, AddrStatus};
    #1 check("rst_status", rdata, 32'd0);
    r_addr = {20'b0, AddrRes};
    #1 check("rst_res0", rdata, 32'd0);
    r_en = 1'b0;
    @(negedge clk) rst = 1'b0;

    // Directed run with cycle-exact status timing
    set_directed();
    load_all();
    start();
    repeat (81) @(posedge clk);
    #1 r_en = 1'b1; r_addr = {20'b0, AddrStatus};
    #1 check("status_at81", rdata, 32'd0);
    check("done_at81", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1 check("status_at82", rdata, 32'd1);
    check("latency_dir", 32'(cyc_cnt - start_cyc), 32'd82);
    r_en = 1'b0;
    check_results("dir");

    // Kernel write and second start while busy are both ignored
    start();
    wr(AddrKern, {16'd0, 8'h00, 8'd200});
    wr(AddrStart, 32'd1);
    wait_done("busy_ign");
    check_results("busy_ign");

    // Disabled write, out-of-range indices, gated and unmapped reads
    cnn_en = 1'b0;
    wr(AddrPix, {16'd0, 8'h00, 8'd99});
    cnn_en = 1'b1;
    wr(AddrPix, {16'd32, 8'h00, 8'd7});
    wr(AddrKern, {16'd16, 8'h00, 8'd7});
    start();
    wait_done("gated");
    check_results("gated");
    @(negedge clk);
    r_en = 1'b0; r_addr = {20'b0, AddrRes};
    #1 check("ren0_read", rdata, 32'd0);
    cnn_en = 1'b0; r_en = 1'b1;
    #1 check("en0_read", rdata, 32'd0);
    cnn_en = 1'b1; r_en = 1'b0;
    rd(12'h0A4, rd_val); check("unmapped_res9", rd_val, 32'd0);
    rd(12'h014, rd_val); check("unmapped_014", rd_val, 32'd0);
    rd(12'h082, rd_val); check("unaligned_082", rd_val, 32'd0);

    // Saturated operands: largest possible sum still fits
    for (int i = 0; i < 25; i++) img_m[i] = 255;
    for (int i = 0; i < 9; i++)  ker_m[i] = 255;
    load_all();
    start();
    wait_done("max");
    for (int i = 0; i < 9; i++) exp_m[i] = 585225;
    check_results("max");

    // Randomized loads against the model; trial 1 drops cnn_en while busy
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 25; i++) img_m[i] = int'($urandom_range(0, 255));
      for (int i = 0; i < 9; i++)  ker_m[i] = int'($urandom_range(0, 255));
      compute_model();
      load_all();
      start();
      if (t == 1) begin
        @(negedge clk) cnn_en = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk) cnn_en = 1'b1;
      end
      wait_done($sformatf("rand%0d", t));
      check_results($sformatf("rand%0d", t));
    end

    // Reset mid-computation aborts and clears everything
    start();
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("midrst_done", {31'b0, done}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (100) @(posedge clk);
    #1 check("midrst_done_after", {31'b0, done}, 32'd0);
    for (int i = 0; i < 9; i++) exp_m[i] = 0;
    check_results("midrst");

    set_directed();
    load_all();
    start();
    wait_done("reload");
    check_results("reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
